freq_gate_counter: RTL
======================

# freq_gate_counter

Consumer end of the frequency-meter gate: counts rising edges of an external, asynchronous input signal while the 1 s gate from the gate generator is high. On each gate falling edge it latches the count, which is the measured frequency in Hz. It pulses a one-cycle valid strobe for the display/readout path. It sits between the gate generator and the result display logic, all on the system clock.

## Interface
- CNT_WIDTH, 28, width of edge counter and result; 28 bits covers 100 MHz × 1 s
- SYNC_STAGES, 2, flops in the Sig_In synchronizer; minimum 2
- Clk  input  1  system clock, 100 MHz
- Rst_n  input  1  reset; one clock, reset is synchronous and active-low
- Gate_Signal  input  1  gate from the gate generator, synchronous to Clk; high = measure window
- Sig_In  input  1  signal under test, asynchronous to Clk
- Freq_Out  output  CNT_WIDTH  last latched edge count
- Freq_Valid  output  1  one-cycle pulse when Freq_Out updates
- Overflow  output  1  latched with Freq_Out; 1 = count saturated in that window

## Operation
- **Sig_In synchronizer:** SYNC_STAGES flops. Then an edge register `Sig_Prev`. `Edge_Pulse = Sync_Last & ~Sig_Prev`.
- **Gate edge detection:** `Gate_d` holds the previous cycle's Gate_Signal.
  - `Gate_Rise = Gate_Signal & ~Gate_d`
  - `Gate_Fall = ~Gate_Signal & Gate_d`
- **FSM states:**
  - **WAIT_LOW** (reset state): discard any window already open at reset. Gate_Signal == 0 → ARMED.
  - **ARMED:** `Gate_Rise` → COUNT. In that same cycle, `Count <= Edge_Pulse ? 1 : 0`.
  - **COUNT:**
    - Gate_Signal == 1: `Edge_Pulse` increments Count.
    - `Gate_Fall`: `Freq_Out <= Count`, `Overflow <= Sat`, `Freq_Valid <= 1` next cycle → ARMED. An `Edge_Pulse` in the fall cycle is not counted.
- **Saturation:** Count stops at 2^CNT_WIDTH−1 and never wraps. Any further `Edge_Pulse` at max sets `Sat`.
- **Sat clearing:** `Sat` clears on `Gate_Rise`.
- **Output hold:** Freq_Out and Overflow hold between windows and change only on a latch.
- **Reset values:** while Rst_n == 0 at a Clk edge:
  - Freq_Out = 0, Freq_Valid = 0, Overflow = 0
  - Count = 0, Sat = 0
  - synchronizer and `Sig_Prev` = 0
  - `Gate_d` = 0
  - state = WAIT_LOW
- **Reset mid-window:** the partial count is discarded and no valid pulse is issued. After reset, the first result comes only after a complete low→high→low gate sequence.
- **Input rate limit:** each Sig_In high and low phase must be ≥ 2 Clk periods. Faster inputs may lose edges; this is not detected.

## Timing
- **Sig_In latency:** a Sig_In rising edge sampled at Clk edge k produces `Edge_Pulse` at k+SYNC_STAGES. It is counted on that edge if Gate_Signal == 1.
- **Result latency:** Gate_Signal seen low at edge f (the `Gate_Fall` cycle):
  - Freq_Out and Overflow update at f+1.
  - Freq_Valid is high for exactly the cycle after f+1 settles, i.e. registered at f+1 and cleared at f+2.
- **Pulse rules:** Freq_Valid is never high two consecutive cycles. It pulses at most once per gate window.
- **Back-to-back windows:** a Gate_Signal low phase of a single cycle still produces the latch, and the next window starts counting on the next `Gate_Rise`.
- **Simultaneous events:**
  - `Gate_Rise` and `Edge_Pulse` in the same cycle: counted (Count = 1).
  - `Gate_Fall` and `Edge_Pulse` in the same cycle: not counted.
  - Saturation and `Gate_Fall` in the same cycle: Overflow reflects `Sat` as of before that cycle.

## Test plan
- **Basic count:** CNT_WIDTH=28; Gate high 1000 cycles; Sig_In period 10 cycles (5 high/5 low) → Freq_Out = 100 ±1, Overflow = 0, one Freq_Valid pulse 1 cycle after gate fall.
- **Saturation:** CNT_WIDTH=4; Gate high 200 cycles; Sig_In period 4 cycles → Freq_Out = 15, Overflow = 1. Next window with 3 edges → Freq_Out = 3, Overflow = 0.
- **Start-up discard:** Gate_Signal = 1 when Rst_n deasserts, then falls after 50 cycles → no Freq_Valid. The next full window gives a correct count.
- **Reset mid-window:** Rst_n low for 1 cycle during COUNT → Freq_Out = 0 and no Freq_Valid for that window. The following complete window reports correctly.
- **Edge coincidence:** force `Edge_Pulse` in the `Gate_Rise` cycle and in the `Gate_Fall` cycle, with 5 edges between → Freq_Out = 6.
- **Zero input and short low phase:** Sig_In held low, two windows separated by a 1-cycle gate low → two Freq_Valid pulses, both Freq_Out = 0.

Source files
------------

// File: rtl/freq_gate_counter_if.sv
// Signal bundle between the gate generator, the signal under test, the
// frequency gate counter and the result readout.
//
// Signals:
//   Gate_Signal  gate window from the gate generator, synchronous to Clk
//   Sig_In       signal under test, asynchronous to Clk
//   Freq_Out     last latched edge count (Hz for a 1 s gate)
//   Freq_Valid   one-cycle strobe when Freq_Out updates
//   Overflow     latched with Freq_Out; 1 = count saturated in that window
//
// Modports:
//   master  the counter: takes gate and signal, drives the result
//   slave   the environment: drives gate and signal, takes the result
interface freq_gate_counter_if #(
    parameter int unsigned CNT_WIDTH = 28
);
    logic                 Gate_Signal;
    logic                 Sig_In;
    logic [CNT_WIDTH-1:0] Freq_Out;
    logic                 Freq_Valid;
    logic                 Overflow;

    modport master (
        input  Gate_Signal,
        input  Sig_In,
        output Freq_Out,
        output Freq_Valid,
        output Overflow
    );

    modport slave (
        output Gate_Signal,
        output Sig_In,
        input  Freq_Out,
        input  Freq_Valid,
        input  Overflow
    );
endinterface

// File: rtl/freq_gate_counter.sv
// Frequency gate counter: counts rising edges of an asynchronous input while
// the gate window is high and latches the count on the gate falling edge.
//
// Ports:
//   Clk    system clock
//   Rst_n  synchronous active-low reset
//   bus    freq_gate_counter_if master modport (gate/signal in, result out)
//
// Parameters:
//   CNT_WIDTH    width of the edge counter and result
//   SYNC_STAGES  flops in the Sig_In synchronizer (minimum 2)
module freq_gate_counter #(
    parameter int unsigned CNT_WIDTH   = 28,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    freq_gate_counter_if.master   bus
);

    localparam logic [1:0] WAIT_LOW = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] COUNTING = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_prev_q;
    logic                   gate_d_q;
    logic [1:0]             state_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   sat_q;
    logic [CNT_WIDTH-1:0]   freq_q;
    logic                   valid_q;
    logic                   ovf_q;

    logic sync_last;
    logic edge_pulse;
    logic gate_rise;
    logic gate_fall;

    always_comb begin
        sync_last  = sync_q[SYNC_STAGES-1];
        edge_pulse = sync_last & ~sig_prev_q;
        gate_rise  = bus.Gate_Signal & ~gate_d_q;
        gate_fall  = ~bus.Gate_Signal & gate_d_q;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            sync_q     <= '0;
            sig_prev_q <= 1'b0;
            gate_d_q   <= 1'b0;
            state_q    <= WAIT_LOW;
            count_q    <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.Sig_In};
            sig_prev_q <= sync_last;
            gate_d_q   <= bus.Gate_Signal;
            valid_q    <= 1'b0;

            case (state_q)
                // A window already open when reset releases is never measured.
                WAIT_LOW: begin
                    if (!bus.Gate_Signal) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (gate_rise) begin
                        state_q <= COUNTING;
                        count_q <= {{(CNT_WIDTH-1){1'b0}}, edge_pulse};
                        sat_q   <= 1'b0;
                    end
                end
                COUNTING: begin
                    // Edge in the fall cycle is dropped; Overflow takes the
                    // saturation flag as it stood before this cycle.
                    if (gate_fall) begin
                        freq_q  <= count_q;
                        ovf_q   <= sat_q;
                        valid_q <= 1'b1;
                        state_q <= ARMED;
                    end else if (edge_pulse) begin
                        if (count_q == CNT_MAX) begin
                            sat_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= WAIT_LOW;
                end
            endcase
        end
    end

    assign bus.Freq_Out   = freq_q;
    assign bus.Freq_Valid = valid_q;
    assign bus.Overflow   = ovf_q;

endmodule
